rr_mux_arbiter: RTL

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

---
 rtl/mux_arb_pkg.sv | 9 +
 rtl/rr_pick4.sv | 17 +
 rtl/rr_mux_arbiter.sv | 79 +++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared types and sizes for the round-robin mux arbiter
package mux_arb_pkg;
   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;
   typedef enum logic {ST_IDLE, ST_GRANT} state_t;
   function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] i);
      return NUM_REQ'(1) << i;
   endfunction
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational round-robin picker, first request at or after ptr
module rr_pick4
   import mux_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [SEL_W-1:0]   i_ptr,
   output logic               o_found,
   output logic [SEL_W-1:0]   o_idx
);
   // scan downward from the farthest offset so the nearest hit wins
   always_comb begin
      o_found = |i_req;
      o_idx   = i_ptr;
      for (int i = NUM_REQ - 1; i >= 0; i--)
         if (i_req[i_ptr + SEL_W'(i)]) o_idx = i_ptr + SEL_W'(i);
   end
endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: 4-way round-robin arbiter with hold limit driving a shared bit mux
module rr_mux_arbiter
   import mux_arb_pkg::*;
#(
   parameter int MAX_HOLD = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] din,
   output logic [NUM_REQ-1:0] gnt,
   output logic [SEL_W-1:0]   sel,
   output logic               busy,
   output logic               y
);
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
   state_t             r_state;
   logic [SEL_W-1:0]   r_ptr;
   logic [SEL_W-1:0]   r_sel;
   logic [NUM_REQ-1:0] r_gnt;
   logic               r_busy;
   logic [7:0]         r_hold;
   logic [NUM_REQ-1:0] w_pick_req;
   logic [SEL_W-1:0]   w_pick_ptr;
   logic               w_found;
   logic [SEL_W-1:0]   w_idx;
   logic               w_release;
   logic               w_expire;
   // while granted, search the others starting just past the owner
   always_comb begin
      w_pick_req = (r_state == ST_GRANT) ? (req & ~r_gnt) : req;
      w_pick_ptr = (r_state == ST_GRANT) ? r_sel + SEL_W'(1) : r_ptr;
      w_release  = (r_state == ST_GRANT) && !req[r_sel];
      w_expire   = (r_state == ST_GRANT) && (r_hold >= HOLD_LAST);
   end
   rr_pick4 u_pick (
      .i_req   (w_pick_req),
      .i_ptr   (w_pick_ptr),
      .o_found (w_found),
      .o_idx   (w_idx)
   );
   // FSM: grant from idle, hand over on release or hold expiry, else keep counting
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_sel   <= '0;
         r_gnt   <= '0;
         r_busy  <= 1'b0;
         r_hold  <= '0;
      end else if (r_state == ST_IDLE) begin
         if (w_found) begin
            r_state <= ST_GRANT;
            r_sel   <= w_idx;
            r_gnt   <= onehot(w_idx);
            r_busy  <= 1'b1;
            r_hold  <= '0;
         end
      end else if (w_release || w_expire) begin
         r_hold <= '0;
         if (w_found) begin
            r_ptr <= r_sel + SEL_W'(1);
            r_sel <= w_idx;
            r_gnt <= onehot(w_idx);
         end else if (w_release) begin
            r_ptr   <= r_sel + SEL_W'(1);
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
         end
      end else begin
         r_hold <= (r_hold == 8'hFF) ? r_hold : r_hold + 8'd1;
      end
   end
   assign gnt  = r_gnt;
   assign sel  = r_sel;
   assign busy = r_busy;
   assign y    = r_busy & din[r_sel];
endmodule
